dvp_source: RTL and testbench

- Camera-side DVP transmitter, the counterpart of the DVP_Capture receiver.
- Takes an RGB565 pixel stream and emits OV5640-style Vsync/Href/8-bit data, two bytes per pixel, high byte first.
- Used to drive the capture -> sdram_control_top -> display path from SDRAM readback or a test source, without a physical camera.
- Downstream samples outputs on Clk; at top level, Clk is wired as the receiver's PCLK.

---
 rtl/dvp_source.sv | 196 +++++++++++++++++++
 tb/tb_dvp_source.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/dvp_source.sv
// dvp_source: RGB565 pixel stream to OV5640-style DVP (Vsync/Href/8-bit Data), two bytes per pixel, high byte first.
// Define DVP_SOURCE_TESTPAT_EN to add Pattern_sel and an internal 8-band colour bar source.
module dvp_source #(
  parameter int IMAGE_WIDTH  = 800,
  parameter int IMAGE_HEIGHT = 480,
  parameter int H_BLANK      = 40,
  parameter int VSYNC_LINES  = 2,
  parameter int V_FRONT      = 2,
  parameter int V_BACK       = 2
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Enable,
`ifdef DVP_SOURCE_TESTPAT_EN
  input  logic        Pattern_sel,
`endif
  input  logic        In_valid,
  input  logic [15:0] In_data,
  output logic        In_ready,
  output logic        Vsync,
  output logic        Href,
  output logic [7:0]  Data,
  output logic        Frame_done,
  output logic        Underrun,
  output logic        Busy
);

  localparam int LINE_LEN = 2*IMAGE_WIDTH + H_BLANK;
  localparam int H_W      = $clog2(LINE_LEN);
  localparam int V_MAX_A  = (VSYNC_LINES > V_FRONT) ? VSYNC_LINES : V_FRONT;
  localparam int V_MAX_B  = (IMAGE_HEIGHT > V_BACK) ? IMAGE_HEIGHT : V_BACK;
  localparam int V_MAX    = (V_MAX_A > V_MAX_B) ? V_MAX_A : V_MAX_B;
  localparam int V_W      = $clog2(V_MAX + 1);

  localparam logic [H_W-1:0] H_LAST   = H_W'(LINE_LEN - 1);
  localparam logic [H_W-1:0] H_ACT    = H_W'(2*IMAGE_WIDTH);
  localparam logic [H_W-1:0] H_ONE    = H_W'(1);
  localparam logic [V_W-1:0] V_ONE    = V_W'(1);
  localparam logic [V_W-1:0] VS_LAST  = V_W'(VSYNC_LINES - 1);
  localparam logic [V_W-1:0] VF_LAST  = V_W'((V_FRONT > 0) ? V_FRONT - 1 : 0);
  localparam logic [V_W-1:0] ACT_LAST = V_W'(IMAGE_HEIGHT - 1);
  localparam logic [V_W-1:0] VB_LAST  = V_W'((V_BACK > 0) ? V_BACK - 1 : 0);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_VSYNC  = 3'd1;
  localparam logic [2:0] ST_VFRONT = 3'd2;
  localparam logic [2:0] ST_ACTIVE = 3'd3;
  localparam logic [2:0] ST_VBACK  = 3'd4;

  logic [2:0]     state_r;
  logic [2:0]     state_nx_s;
  logic [H_W-1:0] h_cnt_r;
  logic [V_W-1:0] v_cnt_r;
  logic [7:0]     lo_byte_r;
  logic           line_end_s;
  logic           frame_end_s;
  logic           slot_s;
  logic           even_s;
  logic           ready_s;
  logic           starve_s;
  logic [15:0]    pixel_s;

`ifdef DVP_SOURCE_TESTPAT_EN
  logic           pattern_r;
  logic [2:0]     band_s;

  function automatic logic [15:0] bar_colour(input logic [2:0] band);
    case (band)
      3'd0:    bar_colour = 16'hFFFF;
      3'd1:    bar_colour = 16'hFFE0;
      3'd2:    bar_colour = 16'h07FF;
      3'd3:    bar_colour = 16'h07E0;
      3'd4:    bar_colour = 16'hF81F;
      3'd5:    bar_colour = 16'hF800;
      3'd6:    bar_colour = 16'h001F;
      default: bar_colour = 16'h0000;
    endcase
  endfunction
`endif

  // Next-state decode; a state ends on the last clock of its last line period
  always_comb begin
    line_end_s  = (h_cnt_r == H_LAST);
    state_nx_s  = state_r;
    frame_end_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (Enable) state_nx_s = ST_VSYNC;
        else        state_nx_s = ST_IDLE;
      end
      ST_VSYNC: begin
        if (line_end_s && (v_cnt_r == VS_LAST)) state_nx_s = (V_FRONT == 0) ? ST_ACTIVE : ST_VFRONT;
        else                                     state_nx_s = ST_VSYNC;
      end
      ST_VFRONT: begin
        if (line_end_s && (v_cnt_r == VF_LAST)) state_nx_s = ST_ACTIVE;
        else                                     state_nx_s = ST_VFRONT;
      end
      ST_ACTIVE: begin
        if (line_end_s && (v_cnt_r == ACT_LAST)) begin
          if (V_BACK == 0) begin
            frame_end_s = 1'b1;
            state_nx_s  = Enable ? ST_VSYNC : ST_IDLE;
          end else begin
            state_nx_s  = ST_VBACK;
          end
        end else begin
          state_nx_s = ST_ACTIVE;
        end
      end
      ST_VBACK: begin
        if (line_end_s && (v_cnt_r == VB_LAST)) begin
          frame_end_s = 1'b1;
          state_nx_s  = Enable ? ST_VSYNC : ST_IDLE;
        end else begin
          state_nx_s  = ST_VBACK;
        end
      end
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // Byte-slot decode and pixel source selection
  always_comb begin
    slot_s = (state_r == ST_ACTIVE) && (h_cnt_r < H_ACT);
    even_s = slot_s && !h_cnt_r[0];
`ifdef DVP_SOURCE_TESTPAT_EN
    band_s  = 3'((32'(h_cnt_r) >> 1) * 32'd8 / 32'(IMAGE_WIDTH));
    ready_s = even_s && !pattern_r;
    if (pattern_r)     pixel_s = bar_colour(band_s);
    else if (In_valid) pixel_s = In_data;
    else               pixel_s = 16'h0000;
`else
    ready_s = even_s;
    if (In_valid) pixel_s = In_data;
    else          pixel_s = 16'h0000;
`endif
    starve_s = ready_s && !In_valid;
  end

  assign In_ready = ready_s;

  // State and line/frame counters; v_cnt restarts whenever the state changes
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_r <= ST_IDLE;
      h_cnt_r <= '0;
      v_cnt_r <= '0;
    end else begin
      state_r <= state_nx_s;
      if (state_r == ST_IDLE) h_cnt_r <= '0;
      else if (line_end_s)    h_cnt_r <= '0;
      else                    h_cnt_r <= h_cnt_r + H_ONE;
      if (state_nx_s != state_r) v_cnt_r <= '0;
      else if (line_end_s)       v_cnt_r <= v_cnt_r + V_ONE;
      else                       v_cnt_r <= v_cnt_r;
    end
  end

`ifdef DVP_SOURCE_TESTPAT_EN
  // Pattern mode is frozen for the whole frame at VSYNC entry
  always_ff @(posedge Clk) begin
    if (Rst)                                                pattern_r <= 1'b0;
    else if ((state_nx_s == ST_VSYNC) && (state_r != ST_VSYNC)) pattern_r <= Pattern_sel;
    else                                                    pattern_r <= pattern_r;
  end
`endif

  // Registered DVP outputs, all one clock behind state/h_cnt
  always_ff @(posedge Clk) begin
    if (Rst) begin
      Vsync      <= 1'b0;
      Href       <= 1'b0;
      Data       <= 8'h00;
      Frame_done <= 1'b0;
      Underrun   <= 1'b0;
      Busy       <= 1'b0;
      lo_byte_r  <= 8'h00;
    end else begin
      Vsync      <= (state_r == ST_VSYNC);
      Href       <= slot_s;
      Busy       <= (state_r != ST_IDLE);
      Frame_done <= frame_end_s;
      if (starve_s) Underrun <= 1'b1;
      if (even_s) begin
        Data      <= pixel_s[15:8];
        lo_byte_r <= pixel_s[7:0];
      end else if (slot_s) begin
        Data      <= lo_byte_r;
      end else begin
        Data      <= 8'h00;
      end
    end
  end

endmodule

// File: tb/tb_dvp_source.sv
// tb_dvp_source: directed and randomized stimulus for dvp_source, checked every cycle against a frame-position model.
module tb_dvp_source;
  localparam int W = 4, H = 2, HB = 4, VSL = 1, VF = 1, VB = 1;
  localparam int LL  = 2*W + HB;
  localparam int FRM = (VSL + VF + H + VB) * LL;

  logic        Clk, Rst, Enable, In_valid, In_ready, Vsync, Href, Frame_done, Underrun, Busy;
  logic [15:0] In_data;
  logic [7:0]  Data;

  int n_checks = 0, n_fail = 0, cyc = 0;

  // model state
  bit          m_known = 0, m_run = 0, m_un = 0;
  int          m_p = 0;
  logic [7:0]  m_lo = 8'h00;
  logic        e_vs, e_hr, e_fd, e_un, e_bz, e_rdy;
  logic [7:0]  e_dt;

  // observed statistics
  int st_vs, st_hr, st_rdy, st_fd, vs_fall_cyc, first_hr_cyc, last_fd_cyc = -1, fd_period = 0;
  logic prev_vs = 0, prev_hr = 0, last_rdy = 0;
  logic [7:0] bytes_q[$];
  logic [15:0] seq [8];
  int pix_k;
  bit found;

  dvp_source #(.IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .H_BLANK(HB), .VSYNC_LINES(VSL), .V_FRONT(VF), .V_BACK(VB)) dut (
    .Clk(Clk), .Rst(Rst), .Enable(Enable),
`ifdef DVP_SOURCE_TESTPAT_EN
    .Pattern_sel(1'b0),
`endif
    .In_valid(In_valid), .In_data(In_data), .In_ready(In_ready), .Vsync(Vsync), .Href(Href),
    .Data(Data), .Frame_done(Frame_done), .Underrun(Underrun), .Busy(Busy));

`ifdef DVP_SOURCE_TESTPAT_EN
  logic       p_rst, p_ready, p_vs, p_hr, p_fd, p_un, p_bz;
  logic [7:0] p_data;
  logic [7:0] pbytes_q[$];
  int         p_rdy_cnt = 0;
  logic [15:0] bars [8];
  dvp_source #(.IMAGE_WIDTH(8), .IMAGE_HEIGHT(1), .H_BLANK(4), .VSYNC_LINES(1), .V_FRONT(1), .V_BACK(1)) dut_pat (
    .Clk(Clk), .Rst(p_rst), .Enable(1'b1), .Pattern_sel(1'b1), .In_valid(1'b0), .In_data(16'h1234),
    .In_ready(p_ready), .Vsync(p_vs), .Href(p_hr), .Data(p_data), .Frame_done(p_fd), .Underrun(p_un), .Busy(p_bz));
`endif

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic clear_stats();
    st_vs = 0; st_hr = 0; st_rdy = 0; st_fd = 0;
    vs_fall_cyc = -1; first_hr_cyc = -1;
    bytes_q.delete();
  endtask

  // One clock: drive inputs at negedge, predict, check In_ready, then check registered outputs at the next negedge
  task automatic cycle(input logic rst, input logic en, input logic valid, input logic [15:0] d);
    int line, col;
    logic act;
    logic [15:0] px;
    Rst = rst; Enable = en; In_valid = valid; In_data = d;
    #1;
    line = 0; col = 0; act = 1'b0;
    if (m_run) begin
      line = m_p / LL;
      col  = m_p % LL;
      act  = (line >= VSL + VF) && (line < VSL + VF + H) && (col < 2*W);
    end
    e_rdy = act && (col % 2 == 0);
    if (m_known) check("in_ready", 16'(In_ready), 16'(e_rdy));
    last_rdy = In_ready;
    if (In_ready === 1'b1) st_rdy++;
    if (rst) begin
      {e_vs, e_hr, e_fd, e_un, e_bz} = 5'b0; e_dt = 8'h00;
      m_run = 0; m_un = 0; m_known = 1;
    end else if (!m_run) begin
      {e_vs, e_hr, e_fd, e_bz} = 4'b0; e_dt = 8'h00; e_un = m_un;
      if (en) begin m_run = 1; m_p = 0; end
    end else begin
      e_vs = (line < VSL);
      e_hr = act;
      e_fd = (m_p == FRM - 1);
      e_bz = 1'b1;
      if (e_rdy) begin
        px = valid ? d : 16'h0000;
        if (!valid) m_un = 1;
        e_dt = px[15:8];
        m_lo = px[7:0];
      end else if (act) e_dt = m_lo;
      else e_dt = 8'h00;
      e_un = m_un;
      m_p++;
      if (m_p == FRM) begin
        if (en) m_p = 0;
        else m_run = 0;
      end
    end
    @(posedge Clk);
    @(negedge Clk);
    cyc++;
    if (m_known) begin
      check("vsync", 16'(Vsync), 16'(e_vs));
      check("href", 16'(Href), 16'(e_hr));
      check("data", 16'(Data), 16'(e_dt));
      check("frame_done", 16'(Frame_done), 16'(e_fd));
      check("underrun", 16'(Underrun), 16'(e_un));
      check("busy", 16'(Busy), 16'(e_bz));
    end
    if (Vsync === 1'b1) st_vs++;
    if (prev_vs && !Vsync) vs_fall_cyc = cyc;
    if (Href === 1'b1) begin
      st_hr++;
      bytes_q.push_back(Data);
      if (!prev_hr && first_hr_cyc < 0) first_hr_cyc = cyc;
    end
    if (Frame_done === 1'b1) begin
      st_fd++;
      if (last_fd_cyc >= 0) fd_period = cyc - last_fd_cyc;
      last_fd_cyc = cyc;
    end
    prev_vs = Vsync; prev_hr = Href;
`ifdef DVP_SOURCE_TESTPAT_EN
    if (!p_rst && p_hr === 1'b1 && pbytes_q.size() < 16) pbytes_q.push_back(p_data);
    if (!p_rst && p_ready !== 1'b0) p_rdy_cnt++;
`endif
  endtask

  initial begin
    seq = '{16'hA1B2, 16'hC3D4, 16'hE5F6, 16'h1728, 16'h394A, 16'h5B6C, 16'h7D8E, 16'h9FA0};
    Rst = 1'b1; Enable = 1'b0; In_valid = 1'b0; In_data = 16'h0000;
`ifdef DVP_SOURCE_TESTPAT_EN
    bars = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0, 16'hF81F, 16'hF800, 16'h001F, 16'h0000};
    p_rst = 1'b1;
`endif
    @(negedge Clk);
    repeat (3) cycle(1'b1, 1'b0, 1'b1, 16'h0000);
`ifdef DVP_SOURCE_TESTPAT_EN
    p_rst = 1'b0;
`endif
    check("rst_busy", 16'(Busy), 16'h0);
    check("rst_href", 16'(Href), 16'h0);

    // frame 1: timing and byte order
    clear_stats(); pix_k = 0;
    repeat (1 + FRM) begin
      cycle(1'b0, 1'b1, 1'b1, seq[pix_k % 8]);
      if (last_rdy) pix_k++;
    end
    check("vsync_len", 16'(st_vs), 16'd12);
    check("href_cnt", 16'(st_hr), 16'd16);
    check("ready_cnt", 16'(st_rdy), 16'd8);
    check("fd_cnt", 16'(st_fd), 16'd1);
    check("href_offset", 16'(first_hr_cyc - vs_fall_cyc), 16'd12);
    check("byte0", 16'(bytes_q[0]), 16'h00A1);
    check("byte1", 16'(bytes_q[1]), 16'h00B2);
    check("byte2", 16'(bytes_q[2]), 16'h00C3);
    check("byte3", 16'(bytes_q[3]), 16'h00D4);
    check("byte15", 16'(bytes_q[15]), 16'h00A0);

    // frame 2: underrun on the third pixel slot
    clear_stats(); pix_k = 0;
    repeat (FRM) begin
      cycle(1'b0, 1'b1, (pix_k != 2), seq[pix_k % 8]);
      if (last_rdy) pix_k++;
    end
    check("ur_byte4", 16'(bytes_q[4]), 16'h0000);
    check("ur_byte5", 16'(bytes_q[5]), 16'h0000);
    check("ur_byte6", 16'(bytes_q[6]), 16'h0017);
    check("ur_href_cnt", 16'(st_hr), 16'd16);
    check("fd_period", 16'(fd_period), 16'd60);
    check("ur_sticky", 16'(Underrun), 16'h1);
    repeat (5) cycle(1'b0, 1'b1, 1'b1, 16'h5555);
    check("ur_held", 16'(Underrun), 16'h1);

    // enable dropped mid-ACTIVE
    repeat (2) cycle(1'b1, 1'b0, 1'b1, 16'h0000);
    clear_stats();
    repeat (31) cycle(1'b0, 1'b1, 1'b1, 16'(($urandom)));
    repeat (150) cycle(1'b0, 1'b0, 1'b1, 16'(($urandom)));
    check("drop_fd_cnt", 16'(st_fd), 16'd1);
    check("drop_busy", 16'(Busy), 16'h0);
    check("drop_vsync", 16'(Vsync), 16'h0);

    // reset during Href
    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      cycle(1'b0, 1'b1, 1'b0, 16'h0000);
      if (Href === 1'b1) found = 1;
    end
    check("href_seen", 16'(found), 16'h1);
    cycle(1'b1, 1'b1, 1'b1, 16'h0000);
    check("mid_rst_href", 16'(Href), 16'h0);
    check("mid_rst_data", 16'(Data), 16'h0);
    check("mid_rst_busy", 16'(Busy), 16'h0);
    check("mid_rst_underrun", 16'(Underrun), 16'h0);
    clear_stats();
    repeat (1 + FRM) cycle(1'b0, 1'b1, 1'b1, 16'(($urandom)));
    check("restart_fd", 16'(Frame_done), 16'h1);
    check("restart_fd_cnt", 16'(st_fd), 16'd1);
    check("restart_vsync_len", 16'(st_vs), 16'd12);

    // randomized traffic
    for (int i = 0; i < 3000; i++)
      cycle(($urandom_range(0, 499) == 0), ($urandom_range(0, 9) != 0),
            ($urandom_range(0, 7) != 0), 16'(($urandom)));

`ifdef DVP_SOURCE_TESTPAT_EN
    check("pat_bytes", 16'(pbytes_q.size()), 16'd16);
    for (int b = 0; b < 8; b++) begin
      if (pbytes_q.size() == 16) begin
        check("pat_hi", 16'(pbytes_q[2*b]), 16'(bars[b][15:8]));
        check("pat_lo", 16'(pbytes_q[2*b+1]), 16'(bars[b][7:0]));
      end
    end
    check("pat_ready", 16'(p_rdy_cnt), 16'd0);
    check("pat_underrun", 16'(p_un), 16'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
